// File: rtl/multi_cycle_control.sv
// Multi-cycle control sequencer for the MIPS-subset datapath, with a memory handshake timeout.
// Define MCC_PERF_CNT_EN to add the RetiredCnt / StallCnt performance counters.
module multi_cycle_control #(
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned TO_W        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  OpCode,
    input  logic [5:0]  Func,
    input  logic        Zero,
    input  logic        MemReady,
    input  logic        Halt,
    output logic        IorD,
    output logic        MemRead,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        RegWrite,
    output logic        Mem2Reg,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [3:0]  ALUControl,
    output logic        ExtOp,
    output logic        PCWrite,
    output logic [1:0]  PCSrc,
    output logic        InstrDone,
    output logic        IllegalInstr,
    output logic        Fault,
    output logic [3:0]  State
`ifdef MCC_PERF_CNT_EN
    ,
    output logic [31:0] RetiredCnt,
    output logic [31:0] StallCnt
`endif
);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_R_EXEC   = 4'd3,
        S_R_WB     = 4'd4,
        S_I_EXEC   = 4'd5,
        S_I_WB     = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WB   = 4'd9,
        S_MEM_WR   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_FAULT    = 4'd15
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [TO_W:0] TO_LIM = (TO_W + 1)'(TIMEOUT_CYC);

    state_t            state;
    state_t            state_nx;
    state_t            boundary;
    logic [TO_W-1:0]   to_cnt;
    logic [TO_W:0]     to_inc;
    logic              mem_state;
    logic              waiting;
    logic              timed_out;
    logic              is_add, is_sub, is_ori, is_lw, is_sw, is_beq, is_j;

    assign is_add = (OpCode == 6'b000000) && (Func == 6'b100000);
    assign is_sub = (OpCode == 6'b000000) && (Func == 6'b100010);
    assign is_ori = (OpCode == 6'b001101);
    assign is_lw  = (OpCode == 6'b100011);
    assign is_sw  = (OpCode == 6'b101011);
    assign is_beq = (OpCode == 6'b000100);
    assign is_j   = (OpCode == 6'b000010);

    assign mem_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign waiting   = mem_state && !MemReady;
    assign to_inc    = {1'b0, to_cnt} + (TO_W + 1)'(1);
    // Fault fires in the wait cycle that brings the count up to the limit.
    assign timed_out = (TIMEOUT_CYC != 0) && waiting && (to_inc == TO_LIM);
    assign boundary  = Halt ? S_IDLE : S_FETCH;

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:     if (!Halt) state_nx = S_FETCH;
            S_FETCH: begin
                if (MemReady)       state_nx = S_DECODE;
                else if (timed_out) state_nx = S_FAULT;
            end
            S_DECODE: begin
                if (is_add || is_sub)    state_nx = S_R_EXEC;
                else if (is_ori)         state_nx = S_I_EXEC;
                else if (is_lw || is_sw) state_nx = S_MEM_ADDR;
                else if (is_beq)         state_nx = S_BRANCH;
                else if (is_j)           state_nx = S_JUMP;
                else                     state_nx = boundary;
            end
            S_R_EXEC:   state_nx = S_R_WB;
            S_I_EXEC:   state_nx = S_I_WB;
            S_MEM_ADDR: state_nx = is_lw ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (MemReady)       state_nx = S_MEM_WB;
                else if (timed_out) state_nx = S_FAULT;
            end
            S_MEM_WR: begin
                if (MemReady)       state_nx = boundary;
                else if (timed_out) state_nx = S_FAULT;
            end
            S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_nx = boundary;
            S_FAULT:    state_nx = S_FAULT;
            default:    state_nx = S_FETCH;
        endcase
    end

    // Any state change clears the wait counter, so it restarts on every memory-state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            to_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state_nx != state) to_cnt <= '0;
            else if (waiting)      to_cnt <= to_inc[TO_W-1:0];
        end
    end

    always_comb begin
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegDst       = 1'b0;
        RegWrite     = 1'b0;
        Mem2Reg      = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUControl   = 4'b0000;
        ExtOp        = 1'b0;
        PCWrite      = 1'b0;
        PCSrc        = 2'b00;
        InstrDone    = 1'b0;
        IllegalInstr = 1'b0;
        Fault        = 1'b0;
        case (state)
            S_FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = ALU_ADD;
                IRWrite    = MemReady;
                PCWrite    = MemReady;
            end
            S_DECODE: begin
                ALUSrcB      = 2'b11;
                ALUControl   = ALU_ADD;
                ExtOp        = 1'b1;
                IllegalInstr = !(is_add || is_sub || is_ori || is_lw || is_sw || is_beq || is_j);
            end
            S_R_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUControl = is_sub ? ALU_SUB : ALU_ADD;
            end
            S_R_WB: begin
                RegDst    = 1'b1;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_I_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = ALU_OR;
            end
            S_I_WB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEM_ADDR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ExtOp      = 1'b1;
                ALUControl = ALU_ADD;
            end
            S_MEM_RD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite  = 1'b1;
                Mem2Reg   = 1'b1;
                InstrDone = 1'b1;
            end
            S_MEM_WR: begin
                IorD      = 1'b1;
                MemWrite  = 1'b1;
                InstrDone = MemReady;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSrc      = 2'b01;
                PCWrite    = Zero;
                InstrDone  = 1'b1;
            end
            S_JUMP: begin
                PCSrc     = 2'b10;
                PCWrite   = 1'b1;
                InstrDone = 1'b1;
            end
            S_FAULT:  Fault = 1'b1;
            default: ;
        endcase
    end

    assign State = state;

`ifdef MCC_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RetiredCnt <= '0;
            StallCnt   <= '0;
        end else begin
            if (InstrDone) RetiredCnt <= RetiredCnt + 32'd1;
            if (waiting)   StallCnt   <= StallCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Randomized bench for multi_cycle_control: an instruction-level model expands each
// instruction into its expected per-cycle trace, which is replayed and compared.
module tb_multi_cycle_control;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] OpCode, Func;
    logic       Zero, MemReady, Halt;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, RegWrite, Mem2Reg, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [3:0] ALUControl, State;
    logic       ExtOp, PCWrite, InstrDone, IllegalInstr, Fault;

    always #5 clk = ~clk;

    multi_cycle_control #(.TIMEOUT_CYC(TO), .TO_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .Func(Func), .Zero(Zero),
        .MemReady(MemReady), .Halt(Halt), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .RegWrite(RegWrite),
        .Mem2Reg(Mem2Reg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ExtOp(ExtOp), .PCWrite(PCWrite), .PCSrc(PCSrc), .InstrDone(InstrDone),
        .IllegalInstr(IllegalInstr), .Fault(Fault), .State(State)
    );

    typedef struct packed {
        logic       iord, mem_read, mem_write, ir_write, reg_dst, reg_write, mem2reg, alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_ctl;
        logic       ext_op, pc_write;
        logic [1:0] pc_src;
        logic       instr_done, illegal, fault;
        logic [3:0] state;
    } obs_t;

    typedef struct packed {
        logic mr, halt, zero;
        obs_t exp;
    } step_t;

    typedef enum int {K_ADD, K_SUB, K_ORI, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_t;

    obs_t  obs;
    step_t trace[$];
    int    n_chk = 0;
    int    n_pass = 0;
    int    n_ill = 0;
    string knames[8] = '{"add", "sub", "ori", "lw", "sw", "beq", "j", "ill"};

    assign obs = {IorD, MemRead, MemWrite, IRWrite, RegDst, RegWrite, Mem2Reg, ALUSrcA,
                  ALUSrcB, ALUControl, ExtOp, PCWrite, PCSrc, InstrDone, IllegalInstr,
                  Fault, State};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t st_only(input logic [3:0] s);
        obs_t o;
        o = '0;
        o.state = s;
        return o;
    endfunction

    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] fn);
        return (op == 6'b000000 && (fn == 6'b100000 || fn == 6'b100010)) ||
               op == 6'b001101 || op == 6'b100011 || op == 6'b101011 ||
               op == 6'b000100 || op == 6'b000010;
    endfunction

    task automatic push(input obs_t e, input logic mr, input logic z, input logic h);
        step_t s;
        s.mr = mr; s.zero = z; s.halt = h; s.exp = e;
        trace.push_back(s);
    endtask

    task automatic push_fault();
        obs_t e;
        for (int i = 0; i < 3; i++) begin
            e = st_only(4'd15);
            e.fault = 1'b1;
            push(e, rb(), rb(), rb());
        end
    endtask

    task automatic set_instr(input kind_t k);
        logic [5:0] op, fn;
        fn = 6'($urandom);
        case (k)
            K_ADD: begin op = 6'b000000; fn = 6'b100000; end
            K_SUB: begin op = 6'b000000; fn = 6'b100010; end
            K_ORI: op = 6'b001101;
            K_LW:  op = 6'b100011;
            K_SW:  op = 6'b101011;
            K_BEQ: op = 6'b000100;
            K_J:   op = 6'b000010;
            default: begin
                if (n_ill == 0) op = 6'b111111;
                else if (rb()) op = 6'b000000;
                else op = 6'($urandom);
                while (is_legal(op, fn)) begin
                    op = 6'($urandom);
                    fn = 6'($urandom);
                end
                n_ill++;
            end
        endcase
        OpCode = op;
        Func   = fn;
    endtask

    // Expands one instruction into its expected cycle-by-cycle behaviour.
    task automatic build(input kind_t k, input int fw, input int mw, input logic z, input logic hend);
        obs_t e;
        int   nw;
        nw = (fw >= TO) ? TO : fw;
        for (int i = 0; i <= nw; i++) begin
            e = st_only(4'd1);
            e.mem_read = 1'b1; e.alu_src_b = 2'b01; e.alu_ctl = 4'b0010;
            if (i == nw) begin
                if (fw >= TO) begin push_fault(); return; end
                e.ir_write = 1'b1; e.pc_write = 1'b1;
                push(e, 1'b1, rb(), rb());
            end else push(e, 1'b0, rb(), rb());
        end
        e = st_only(4'd2);
        e.alu_src_b = 2'b11; e.alu_ctl = 4'b0010; e.ext_op = 1'b1;
        e.illegal = (k == K_ILL);
        push(e, rb(), rb(), (k == K_ILL) ? hend : rb());
        case (k)
            K_ADD, K_SUB: begin
                e = st_only(4'd3);
                e.alu_src_a = 1'b1; e.alu_ctl = (k == K_SUB) ? 4'b0110 : 4'b0010;
                push(e, rb(), rb(), rb());
                e = st_only(4'd4);
                e.reg_dst = 1'b1; e.reg_write = 1'b1; e.instr_done = 1'b1;
                push(e, rb(), rb(), hend);
            end
            K_ORI: begin
                e = st_only(4'd5);
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctl = 4'b0001;
                push(e, rb(), rb(), rb());
                e = st_only(4'd6);
                e.reg_write = 1'b1; e.instr_done = 1'b1;
                push(e, rb(), rb(), hend);
            end
            K_LW, K_SW: begin
                e = st_only(4'd7);
                e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.ext_op = 1'b1; e.alu_ctl = 4'b0010;
                push(e, rb(), rb(), rb());
                nw = (mw >= TO) ? TO : mw;
                for (int i = 0; i <= nw; i++) begin
                    e = st_only((k == K_LW) ? 4'd8 : 4'd10);
                    e.iord = 1'b1;
                    if (k == K_LW) e.mem_read = 1'b1; else e.mem_write = 1'b1;
                    if (i < nw) push(e, 1'b0, rb(), rb());
                    else if (mw >= TO) begin push_fault(); return; end
                    else if (k == K_SW) begin
                        e.instr_done = 1'b1;
                        push(e, 1'b1, rb(), hend);
                    end else push(e, 1'b1, rb(), rb());
                end
                if (k == K_LW) begin
                    e = st_only(4'd9);
                    e.reg_write = 1'b1; e.mem2reg = 1'b1; e.instr_done = 1'b1;
                    push(e, rb(), rb(), hend);
                end
            end
            K_BEQ: begin
                e = st_only(4'd11);
                e.alu_src_a = 1'b1; e.alu_ctl = 4'b0110; e.pc_src = 2'b01;
                e.pc_write = z; e.instr_done = 1'b1;
                push(e, rb(), z, hend);
            end
            K_J: begin
                e = st_only(4'd12);
                e.pc_src = 2'b10; e.pc_write = 1'b1; e.instr_done = 1'b1;
                push(e, rb(), rb(), hend);
            end
            default: ;
        endcase
        if (hend) begin
            repeat ($urandom_range(0, 2)) push(st_only(4'd0), rb(), rb(), 1'b1);
            push(st_only(4'd0), rb(), rb(), 1'b0);
        end
    endtask

    task automatic play(input string tag);
        step_t s;
        while (trace.size() > 0) begin
            s = trace.pop_front();
            MemReady = s.mr; Halt = s.halt; Zero = s.zero;
            #1;
            chk($sformatf("%s_s%0d", tag, s.exp.state), 32'(obs), 32'(s.exp));
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input kind_t k, input int fw, input int mw, input logic z, input logic hend);
        set_instr(k);
        build(k, fw, mw, z, hend);
        play(knames[k]);
    endtask

    task automatic do_reset();
        Halt  = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 32'(obs), 32'(0));
        @(posedge clk); #1;
        chk("rst_hold", 32'(obs), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_idle", 32'(obs), 32'(0));
        push(st_only(4'd0), rb(), rb(), 1'b0);
        play("idle_rel");
    endtask

    initial begin
        rst_n = 1'b0; Halt = 1'b1; MemReady = 1'b0; Zero = 1'b0;
        OpCode = 6'd0; Func = 6'd0;
        #2;
        do_reset();
        run(K_ADD, 0, 0, 1'b0, 1'b0);
        run(K_LW,  0, 3, 1'b0, 1'b0);
        run(K_BEQ, 0, 0, 1'b1, 1'b0);
        run(K_BEQ, 0, 0, 1'b0, 1'b0);
        run(K_ILL, 0, 0, 1'b0, 1'b0);
        run(K_SUB, 0, 0, 1'b0, 1'b1);
        run(K_SW,  TO - 1, TO - 1, 1'b0, 1'b0);
        run(K_J,   0, 0, 1'b0, 1'b1);
        for (int n = 0; n < 150; n++)
            run(kind_t'($urandom_range(0, 7)), $urandom_range(0, TO - 1),
                $urandom_range(0, TO - 1), rb(), ($urandom_range(0, 4) == 0));
        run(K_ADD, TO, 0, 1'b0, 1'b0);
        do_reset();
        run(K_LW, 0, TO, 1'b0, 1'b0);
        do_reset();
        run(K_SW, 1, TO, 1'b0, 1'b0);
        do_reset();
        run(K_ORI, 0, 0, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Multi-cycle control FSM for the MIPS-subset datapath: ADD, SUB, ORI, LW, SW, BEQ, J.
- Sequences the shared ALU, single unified memory port, instruction register and PC over several cycles per instruction.
- Handles a variable-latency memory handshake with a timeout fault.
- Sits between instruction register and datapath muxes and enables; drop-in successor to the combinational single-cycle Control.

Parameters:
TIMEOUT_CYC, 255, max wait cycles for MemReady per access; 0 disables the timeout.
TO_W, 8, width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  asynchronous active-low reset.
OpCode  in  6  instruction[31:26] from IR.
Func  in  6  instruction[5:0] from IR.
Zero  in  1  ALU zero flag.
MemReady  in  1  memory access complete this cycle.
Halt  in  1  park in IDLE at next instruction boundary.
IorD  out  1  memory address: 0=PC, 1=ALUOut.
MemRead  out  1  memory read request.
MemWrite  out  1  memory write request.
IRWrite  out  1  load IR.
RegDst  out  1  write register: 1=rd, 0=rt.
RegWrite  out  1  register file write enable.
Mem2Reg  out  1  write-back data: 1=MDR, 0=ALUOut.
ALUSrcA  out  1  ALU A input: 0=PC, 1=rs.
ALUSrcB  out  2  ALU B input: 00=rt, 01=const 4, 10=ext imm, 11=ext imm<<2.
ALUControl  out  4  ALU op: 0010=ADD, 0110=SUB, 0001=OR.
ExtOp  out  1  1=sign-extend, 0=zero-extend.
PCWrite  out  1  PC load enable.
PCSrc  out  2  PC source: 00=ALU result, 01=ALUOut (branch target), 10=jump target.
InstrDone  out  1  one-cycle pulse in last state of each legal instruction.
IllegalInstr  out  1  one-cycle pulse on unsupported OpCode/Func.
Fault  out  1  sticky memory-timeout flag.
State  out  4  current state encoding, for debug.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; timeout counter=0; Fault=0.
  - All outputs 0.
- Outputs are Moore-decoded from the state register. Exception: PCWrite in BRANCH = Zero.
- States and encodings:
  - IDLE(0): all outputs 0. Go to FETCH when Halt=0.
  - FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD.
    - IRWrite and PCWrite (PCSrc=00) asserted only in the cycle MemReady=1; then go to DECODE.
    - While MemReady=0: stay, with MemRead held high.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUControl=ADD, ExtOp=1 (precomputes branch target). Dispatch:
    - OpCode 000000 with Func 100000/100010 -> R_EXEC.
    - 001101 -> I_EXEC.
    - 100011/101011 -> MEM_ADDR.
    - 000100 -> BRANCH.
    - 000010 -> JUMP.
    - Anything else -> FETCH (or IDLE if Halt), IllegalInstr=1 for this cycle, no register or memory write.
  - R_EXEC(3): ALUSrcA=1, ALUSrcB=00, ALUControl=ADD or SUB per Func.
  - R_WB(4): RegDst=1, RegWrite=1, Mem2Reg=0, InstrDone=1.
  - I_EXEC(5): ALUSrcA=1, ALUSrcB=10, ExtOp=0, ALUControl=OR.
  - I_WB(6): RegDst=0, RegWrite=1, Mem2Reg=0, InstrDone=1.
  - MEM_ADDR(7): ALUSrcA=1, ALUSrcB=10, ExtOp=1, ALUControl=ADD. Go to MEM_RD (LW) or MEM_WR (SW).
  - MEM_RD(8): IorD=1, MemRead=1. Wait for MemReady, then go to MEM_WB.
  - MEM_WB(9): RegDst=0, RegWrite=1, Mem2Reg=1, InstrDone=1.
  - MEM_WR(10): IorD=1, MemWrite=1. Wait for MemReady; InstrDone=1 in the MemReady cycle.
  - BRANCH(11): ALUSrcA=1, ALUSrcB=00, ALUControl=SUB, PCSrc=01, PCWrite=Zero, InstrDone=1.
  - JUMP(12): PCSrc=10, PCWrite=1, InstrDone=1.
  - FAULT(15): all outputs 0 except Fault=1. Exits only on reset.
- Transitions out of the last state of an instruction:
  - R_WB, I_WB, MEM_WB, MEM_WR-done, BRANCH, JUMP -> FETCH.
  - Go to IDLE instead if Halt=1 in that cycle.
- Halt is ignored mid-instruction.
- Latency with zero-wait memory (MemReady=1 on first request cycle):
  - R-type and ORI: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ and J: 3 cycles.
  - Each memory wait cycle adds 1.
- Timeout counter:
  - Clears on entry to FETCH/MEM_RD/MEM_WR.
  - Increments each cycle MemReady=0 in those states.
  - If TIMEOUT_CYC≠0 and counter reaches TIMEOUT_CYC with MemReady still 0 -> FAULT next cycle.
  - MemReady=1 in the same cycle the limit is reached counts as success.
- MemReady outside memory states is ignored.
- Unused State codes (13, 14) -> FETCH next cycle.

Optional Feature:
- Macro: MCC_PERF_CNT_EN.
- When defined:
  - Adds output RetiredCnt[31:0], incremented on every InstrDone pulse.
  - Adds output StallCnt[31:0], incremented on every memory-wait cycle.
  - Both reset to 0 asynchronously and wrap modulo 2^32.
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Reset then Halt=0, MemReady=1, ADD (000000/100000): states 1,2,3,4. In state 3, ALUControl=0010; in state 4, RegWrite=1 and RegDst=1. InstrDone pulses once; 4 cycles total.
- LW (100011) with MemReady low 3 cycles in MEM_RD: MemRead and IorD held high 4 cycles, then MEM_WB with Mem2Reg=1, RegWrite=1. 8 cycles total.
- BEQ (000100): Zero=1 -> PCWrite=1, PCSrc=01 in BRANCH. Repeat with Zero=0 -> PCWrite=0. Both take 3 cycles.
- OpCode 111111 in DECODE: IllegalInstr=1 for 1 cycle, RegWrite and MemWrite never asserted, next state FETCH.
- TIMEOUT_CYC=4, MemReady held 0 in FETCH: FAULT after 4 wait cycles, Fault=1 and all outputs 0. Stays there until rst_n pulse, then State=IDLE.
- Halt=1 asserted during R_EXEC of SUB: instruction completes (R_WB, ALUControl=0110 in R_EXEC), then IDLE. Release Halt -> FETCH next cycle.
